avalon_arbiter: RTL

AVALON_ARBITER -- requirements
Module: avalon_arbiter

---
 rtl/avalon_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/avalon_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_arbiter
//
// Two-master (ibus, dbus) to one-slave Avalon-MM arbiter with round-robin
// priority, a lock that holds a stalled grant until the slave accepts it, and a
// tag pipeline that routes pipelined read data back to the issuing master.
//
// Parameters
//   READ_LATENCY  slave's fixed cycles from read acceptance to readdata (1..4)
//   AW            address width
//   DW            data width (byte enables are DW/8 wide)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ibus_* / dbus_* (inputs)       read, write, address, writedata, byte_enable
//   ibus_* / dbus_* (outputs)      waitrequest, readdata, readdatavalid
//   s_* (outputs)                  read, write, address, writedata, byte_enable
//   s_* (inputs)                   waitrequest, readdata
// -----------------------------------------------------------------------------
module avalon_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ibus_read_i,
    input  logic            ibus_write_i,
    input  logic [AW-1:0]   ibus_address_i,
    input  logic [DW-1:0]   ibus_writedata_i,
    input  logic [DW/8-1:0] ibus_byte_enable_i,
    output logic            ibus_waitrequest_o,
    output logic [DW-1:0]   ibus_readdata_o,
    output logic            ibus_readdatavalid_o,

    input  logic            dbus_read_i,
    input  logic            dbus_write_i,
    input  logic [AW-1:0]   dbus_address_i,
    input  logic [DW-1:0]   dbus_writedata_i,
    input  logic [DW/8-1:0] dbus_byte_enable_i,
    output logic            dbus_waitrequest_o,
    output logic [DW-1:0]   dbus_readdata_o,
    output logic            dbus_readdatavalid_o,

    output logic            s_read_o,
    output logic            s_write_o,
    output logic [AW-1:0]   s_address_o,
    output logic [DW-1:0]   s_writedata_o,
    output logic [DW/8-1:0] s_byte_enable_o,
    input  logic            s_waitrequest_i,
    input  logic [DW-1:0]   s_readdata_i
);

    typedef enum logic {
        MST_IBUS = 1'b0,
        MST_DBUS = 1'b1
    } master_e;

    // One entry per slave pipeline stage: does the data leaving the slave in
    // that stage belong to a read, and if so which master issued it.
    typedef struct packed {
        logic    valid;
        master_e master;
    } tag_t;

    master_e last_grant_q, last_grant_d;
    logic    lock_q, lock_d;
    master_e lock_master_q, lock_master_d;
    tag_t    tag_q [READ_LATENCY];
    tag_t    tag_in;

    logic    ibus_req;
    logic    dbus_req;
    logic    grant_valid;
    master_e grant_master;
    logic    accept;

    assign ibus_req = ibus_read_i | ibus_write_i;
    assign dbus_req = dbus_read_i | dbus_write_i;

    // -------------------------------------------------------------------------
    // Grant: a held (locked) transfer wins outright; otherwise a lone requester
    // wins, and on contention the master that did not win last time wins. If
    // the locked master has illegally dropped its request there is no grant and
    // the lock falls away at the end of the cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        grant_valid  = 1'b0;
        grant_master = MST_IBUS;
        if (lock_q) begin
            grant_master = lock_master_q;
            grant_valid  = (lock_master_q == MST_IBUS) ? ibus_req : dbus_req;
        end else if (ibus_req && dbus_req) begin
            grant_valid  = 1'b1;
            grant_master = (last_grant_q == MST_IBUS) ? MST_DBUS : MST_IBUS;
        end else if (ibus_req) begin
            grant_valid  = 1'b1;
            grant_master = MST_IBUS;
        end else if (dbus_req) begin
            grant_valid  = 1'b1;
            grant_master = MST_DBUS;
        end
    end

    // Slave-side mux: the granted master passes through untouched, idle bus is 0.
    always_comb begin
        s_read_o        = 1'b0;
        s_write_o       = 1'b0;
        s_address_o     = '0;
        s_writedata_o   = '0;
        s_byte_enable_o = '0;
        if (grant_valid) begin
            if (grant_master == MST_IBUS) begin
                s_read_o        = ibus_read_i;
                s_write_o       = ibus_write_i;
                s_address_o     = ibus_address_i;
                s_writedata_o   = ibus_writedata_i;
                s_byte_enable_o = ibus_byte_enable_i;
            end else begin
                s_read_o        = dbus_read_i;
                s_write_o       = dbus_write_i;
                s_address_o     = dbus_address_i;
                s_writedata_o   = dbus_writedata_i;
                s_byte_enable_o = dbus_byte_enable_i;
            end
        end
    end

    // Granted master sees the slave's stall; a losing requester is stalled;
    // a master that is not requesting is never stalled.
    always_comb begin
        ibus_waitrequest_o = 1'b0;
        dbus_waitrequest_o = 1'b0;
        if (ibus_req) begin
            ibus_waitrequest_o = (grant_valid && grant_master == MST_IBUS) ? s_waitrequest_i : 1'b1;
        end
        if (dbus_req) begin
            dbus_waitrequest_o = (grant_valid && grant_master == MST_DBUS) ? s_waitrequest_i : 1'b1;
        end
    end

    assign accept = grant_valid & ~s_waitrequest_i;

    // Only an accepted read produces data later; writes and idle cycles push an
    // empty tag so the pipeline stays aligned with the slave's fixed latency.
    always_comb begin
        tag_in.valid  = accept & s_read_o;
        tag_in.master = grant_master;
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        lock_d        = 1'b0;
        lock_master_d = lock_master_q;
        if (accept) begin
            last_grant_d = grant_master;
        end else if (grant_valid) begin
            lock_d        = 1'b1;
            lock_master_d = grant_master;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset last_grant to dbus so ibus wins the first contention.
            last_grant_q  <= MST_DBUS;
            lock_q        <= 1'b0;
            lock_master_q <= MST_IBUS;
            // NOTE: the tag pipeline is cleared on reset, unlike a data store,
            // because a stale valid tag would raise readdatavalid for a read the
            // reset has already abandoned.
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples its pre-edge value regardless of statement order.
            last_grant_q  <= last_grant_d;
            lock_q        <= lock_d;
            lock_master_q <= lock_master_d;
            tag_q[0]      <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Read data is shared; only the valid strobe is steered by the tag.
    assign ibus_readdata_o = s_readdata_i;
    assign dbus_readdata_o = s_readdata_i;

    assign ibus_readdatavalid_o = ~rst & tag_q[READ_LATENCY-1].valid
                                  & (tag_q[READ_LATENCY-1].master == MST_IBUS);
    assign dbus_readdatavalid_o = ~rst & tag_q[READ_LATENCY-1].valid
                                  & (tag_q[READ_LATENCY-1].master == MST_DBUS);

endmodule
